// File: rtl/vjtag_cmd_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the JTAG command path (receiver and decoder).
package vjtag_cmd_pkg;

  // Field layout of a 16-bit JTAG command word.
  localparam int unsigned CMD_DW   = 16;
  localparam int unsigned ADDR_MSB = 15;
  localparam int unsigned ADDR_LSB = 12;
  localparam int unsigned TYPE_MSB = 11;
  localparam int unsigned TYPE_LSB = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  // Command type codes carried in the type field.
  localparam logic [3:0] CMD_NOP       = 4'd0;
  localparam logic [3:0] CMD_WRITE_REG = 4'd1;
  localparam logic [3:0] CMD_READ_REG  = 4'd2;
  localparam logic [3:0] CMD_WRITE_MEM = 4'd3;
  localparam logic [3:0] CMD_READ_MEM  = 4'd4;

  // Register file map addressed by the addr field.
  typedef enum logic [3:0] {
    REG_CTRL,
    REG_STATUS,
    REG_MEM_ADDR_LO,
    REG_MEM_ADDR_HI,
    REG_MEM_WDATA,
    REG_MEM_RDATA,
    REG_IRQ_MASK,
    REG_IRQ_STAT,
    REG_SCRATCH0,
    REG_SCRATCH1,
    REG_SCRATCH2,
    REG_SCRATCH3,
    REG_DBG0,
    REG_DBG1,
    REG_DBG2,
    REG_ID
  } reg_addr_t;

  // Receiver control states: INIT absorbs the toggle level after reset.
  typedef enum logic {
    ST_INIT,
    ST_RUN
  } rx_state_t;

  // A NOP word is dropped silently by the receiver.
  function automatic logic is_nop(input logic [CMD_DW-1:0] word);
    return word[TYPE_MSB:TYPE_LSB] == CMD_NOP;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
`timescale 1ns/1ps
// Synchronous first-word-fall-through FIFO; an extra pointer bit separates full from empty.
module cmd_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_pop_ok;
  logic w_push_ok;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign level     = r_wr_ptr - r_rd_ptr;
  assign head_data = r_mem[r_rd_ptr[AW-1:0]];

  // A pop on empty is ignored; a push on full only lands if a pop frees the slot.
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; pointers alone define which entries are valid.
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vjtag_cmd_rx.sv
`timescale 1ns/1ps
// Turns each TCK-domain Update-DR toggle into one buffered clk-domain command.
module vjtag_cmd_rx
  import vjtag_cmd_pkg::*;
#(
  parameter int unsigned DW          = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DW-1:0]                 jtag_word,
  input  logic                          jtag_toggle,
  input  logic                          cmd_ready,
  output logic                          cmd_valid,
  output logic [3:0]                    cmd_addr,
  output logic [3:0]                    cmd_type,
  output logic [7:0]                    cmd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [15:0]                   cmd_count
);

  localparam int unsigned    INIT_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned    CW          = $clog2(INIT_CYCLES + 1);
  localparam logic [CW-1:0]  INIT_LAST   = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE     = CW'(1);

  logic [SYNC_STAGES-1:0] r_tog_sync;
  logic                   r_prev;
  logic [DW-1:0]          r_word_q;
  rx_state_t              r_state;
  logic [CW-1:0]          r_init_cnt;

  rx_state_t              w_state_nxt;
  logic                   w_tog_s;
  logic                   w_edge;
  logic                   w_push_req;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_drop;
  logic                   w_full;
  logic                   w_empty;
  logic [DW-1:0]          w_head;

  assign w_tog_s = r_tog_sync[SYNC_STAGES-1];

  // Toggle synchronizer, previous-toggle flop and word capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tog_sync <= '0;
      r_prev     <= 1'b0;
      r_word_q   <= '0;
    end else begin
      r_tog_sync <= {r_tog_sync[SYNC_STAGES-2:0], jtag_toggle};
      r_prev     <= w_tog_s;
      r_word_q   <= jtag_word;
    end
  end

  // State register and INIT settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + CNT_ONE;
    end
  end

  // Next state and edge detect; edges are suppressed until the synchronizer has settled.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_edge      = 1'b0;
    case (r_state)
      ST_INIT: if (r_init_cnt == INIT_LAST) w_state_nxt = ST_RUN;
      ST_RUN:  w_edge = w_tog_s ^ r_prev;
    endcase
  end

  assign w_pop      = !w_empty && cmd_ready;
  assign w_push_req = w_edge && !is_nop(r_word_q);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // Sticky overflow (set beats clear) and accepted-command counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      cmd_count <= '0;
    end else begin
      if (w_drop)            overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
      if (w_push) cmd_count <= cmd_count + 16'd1;
    end
  end

  cmd_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (r_word_q),
    .pop       (w_pop),
    .head_data (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

  // Head fields are forced to zero while nothing is buffered.
  assign cmd_valid = !w_empty;
  assign cmd_addr  = cmd_valid ? w_head[ADDR_MSB:ADDR_LSB] : 4'd0;
  assign cmd_type  = cmd_valid ? w_head[TYPE_MSB:TYPE_LSB] : 4'd0;
  assign cmd_data  = cmd_valid ? w_head[DATA_MSB:DATA_LSB] : 8'd0;

endmodule

// File: tb/tb_vjtag_cmd_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for vjtag_cmd_rx with a queue-based reference model.
module tb_vjtag_cmd_rx;
  import vjtag_cmd_pkg::*;

  localparam int DW    = 16;
  localparam int SYNC  = 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] jtag_word = '0;
  logic          jtag_toggle = 1'b1;
  logic          cmd_ready = 1'b0;
  logic          cmd_valid;
  logic [3:0]    cmd_addr;
  logic [3:0]    cmd_type;
  logic [7:0]    cmd_data;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          overflow_clr = 1'b0;
  logic [15:0]   cmd_count;

  vjtag_cmd_rx #(
    .DW          (DW),
    .SYNC_STAGES (SYNC),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jtag_word    (jtag_word),
    .jtag_toggle  (jtag_toggle),
    .cmd_ready    (cmd_ready),
    .cmd_valid    (cmd_valid),
    .cmd_addr     (cmd_addr),
    .cmd_type     (cmd_type),
    .cmd_data     (cmd_data),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .cmd_count    (cmd_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a toggle issued after clk edge c lands at edge c+1+SYNC.
  typedef struct {
    int unsigned due;
    logic [15:0] word;
  } arrival_t;

  int unsigned cyc = 0;
  arrival_t    arr_q[$];
  logic [15:0] mdl_q[$];
  logic [15:0] sb_q[$];
  logic        mdl_ovf = 1'b0;
  logic [15:0] mdl_cnt = 16'd0;
  int          valid_cycles = 0;
  int          ready_mode = 1;

  initial begin
    logic [15:0] w;
    logic [15:0] tmp;
    int          sz;
    bit          pop;
    bit          drop;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        arr_q.delete();
        mdl_q.delete();
        sb_q.delete();
        mdl_ovf = 1'b0;
        mdl_cnt = 16'd0;
      end else begin
        cyc++;
        sz   = mdl_q.size();
        pop  = (sz != 0) && cmd_ready;
        drop = 1'b0;
        if (pop) tmp = mdl_q.pop_front();
        if (arr_q.size() != 0 && arr_q[0].due == cyc) begin
          w = arr_q[0].word;
          arr_q.delete(0);
          if (w[11:8] != CMD_NOP) begin
            if (sz < DEPTH || pop) begin
              mdl_q.push_back(w);
              sb_q.push_back(w);
              mdl_cnt = mdl_cnt + 16'd1;
            end else begin
              drop = 1'b1;
            end
          end
        end
        if (drop) mdl_ovf = 1'b1;
        else if (overflow_clr) mdl_ovf = 1'b0;
      end
    end
  end

  // Monitor: compares DUT state against the model and pops the scoreboard on each handshake.
  initial begin
    logic [31:0] exp_head;
    forever begin
      @(negedge clk);
      check("level",    32'(fifo_level), 32'(mdl_q.size()));
      check("valid",    32'(cmd_valid),  32'(mdl_q.size() != 0));
      check("overflow", 32'(overflow),   32'(mdl_ovf));
      check("count",    32'(cmd_count),  32'(mdl_cnt));
      if (cmd_valid) begin
        valid_cycles++;
        exp_head = (sb_q.size() != 0) ? 32'(sb_q[0]) : 32'hDEAD_BEEF;
        check("head", {16'd0, cmd_addr, cmd_type, cmd_data}, exp_head);
        if (cmd_ready && sb_q.size() != 0) sb_q.delete(0);
      end else begin
        check("idle_fields", {16'd0, cmd_addr, cmd_type, cmd_data}, 32'd0);
      end
    end
  end

  // Consumer ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       cmd_ready = 1'b0;
        1:       cmd_ready = 1'b1;
        default: cmd_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One Update-DR: word settles, toggle flips, optional clear aligned with the landing edge.
  task automatic send(input logic [15:0] w, input bit clr_at_push);
    arrival_t a;
    jtag_word = w;
    tick(SYNC + 2);
    a.due  = cyc + 1 + SYNC;
    a.word = w;
    arr_q.push_back(a);
    jtag_toggle = ~jtag_toggle;
    tick(SYNC);
    if (clr_at_push) overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    tick(SYNC + 1);
  endtask

  initial begin
    logic [15:0] w;
    tick(3);
    rst_n = 1'b1;

    // Toggle high across reset release: nothing may be produced.
    tick(50);
    check("init_count", 32'(cmd_count), 32'd0);
    check("init_valid_cycles", 32'(valid_cycles), 32'd0);

    // Single command, consumer always ready.
    valid_cycles = 0;
    send(16'h1105, 1'b0);
    tick(4);
    check("single_valid_cycles", 32'(valid_cycles), 32'd1);
    check("single_count", 32'(cmd_count), 32'd1);

    // Identical word three times: each toggle is a distinct command.
    valid_cycles = 0;
    repeat (3) send(16'h3BAA, 1'b0);
    tick(4);
    check("repeat_valid_cycles", 32'(valid_cycles), 32'd3);
    check("repeat_count", 32'(cmd_count), 32'd4);

    // Fill with consumer stalled; fifth command is lost.
    ready_mode = 0;
    tick(2);
    for (int i = 1; i <= 5; i++) send(16'h1100 + 16'(i), 1'b0);
    tick(2);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_count", 32'(cmd_count), 32'd8);
    ready_mode = 1;
    tick(8);
    check("drain_level", 32'(fifo_level), 32'd0);
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);

    // NOP words are discarded without side effects.
    valid_cycles = 0;
    send(16'h0000, 1'b0);
    send(16'h5077, 1'b0);
    tick(4);
    check("nop_valid_cycles", 32'(valid_cycles), 32'd0);
    check("nop_count", 32'(cmd_count), 32'd8);
    check("nop_overflow", 32'(overflow), 32'd1);

    // Clear coinciding with a new drop: set wins; a lone clear then takes effect.
    ready_mode = 0;
    tick(2);
    for (int i = 0; i < 4; i++) send(16'h2210 + 16'(i), 1'b0);
    send(16'h2277, 1'b1);
    tick(2);
    check("clr_vs_drop_overflow", 32'(overflow), 32'd1);
    check("clr_vs_drop_count", 32'(cmd_count), 32'd12);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    tick(1);
    check("clr_alone_overflow", 32'(overflow), 32'd0);
    ready_mode = 1;
    tick(8);

    // Reset with three buffered commands flushes asynchronously.
    ready_mode = 0;
    tick(2);
    for (int i = 0; i < 3; i++) send(16'h4330 + 16'(i), 1'b0);
    tick(2);
    check("pre_reset_level", 32'(fifo_level), 32'd3);
    rst_n = 1'b0;
    #1;
    check("async_reset_level", 32'(fifo_level), 32'd0);
    check("async_reset_valid", 32'(cmd_valid), 32'd0);
    check("async_reset_count", 32'(cmd_count), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("post_reset_valid_cycles_level", 32'(fifo_level), 32'd0);

    // Randomized traffic: random words (some NOP), random stalls, random clears.
    for (int i = 0; i < 40; i++) begin
      ready_mode = ((i % 10) < 4) ? 0 : 2;
      w = 16'($urandom);
      if ($urandom_range(0, 4) == 0) w[11:8] = CMD_NOP;
      send(w, $urandom_range(0, 3) == 0);
      tick($urandom_range(0, 3));
    end

    // Bounded drain of whatever is left.
    ready_mode = 1;
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) tick(1);
    tick(2);
    check("final_drain", 32'(sb_q.size()), 32'd0);
    check("final_level", 32'(fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
